// File: rtl/pwm_multichannel.sv
// Multichannel Wishbone PWM: shared prescaler and period counter, per-channel duty compare and polarity.
// Period and duty are double-buffered; active copies reload at a wrap, or every cycle while disabled.
module pwm_multichannel #(
  parameter int Channels   = 4,
  parameter int Width      = 8,
  parameter int PrescWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [Channels-1:0] pwm_o,
  output logic                wrap_o
);

  logic                  en_q, en_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [PrescWidth-1:0] pcnt_q, pcnt_d;
  logic [Width-1:0]      period_sh_q, period_sh_d;
  logic [Width-1:0]      period_act_q, period_act_d;
  logic [Width-1:0]      cnt_q, cnt_d;
  logic [Channels-1:0]   pol_q, pol_d;
  logic [Channels-1:0]   pwm_q, pwm_d;
  logic [Channels-1:0]   raw;
  logic [Width-1:0]      duty_sh_q  [Channels];
  logic [Width-1:0]      duty_sh_d  [Channels];
  logic [Width-1:0]      duty_act_q [Channels];
  logic [Width-1:0]      duty_act_d [Channels];
  logic                  wrap_q, wrap_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           rdata;
  logic                  wr, rd, tick, at_top, reload;
  logic                  unused_dat;

  assign unused_dat = ^wb_dat_i;

  // Only the first cycle of a strobe is a real access; the ack cycle is ignored.
  assign wr = wb_stb_i & wb_we_i & ~ack_q;
  assign rd = wb_stb_i & ~wb_we_i & ~ack_q;

  always_comb begin
    en_d        = en_q;
    presc_d     = presc_q;
    period_sh_d = period_sh_q;
    pol_d       = pol_q;
    duty_sh_d   = duty_sh_q;
    if (wr) begin
      case (wb_adr_i)
        4'd0:    en_d        = wb_dat_i[0];
        4'd1:    presc_d     = wb_dat_i[PrescWidth-1:0];
        4'd2:    period_sh_d = wb_dat_i[Width-1:0];
        4'd3:    pol_d       = wb_dat_i[Channels-1:0];
        default: begin
          for (int n = 0; n < Channels; n++) begin
            if (wb_adr_i == 4'(n + 4)) duty_sh_d[n] = wb_dat_i[Width-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      4'd0:    rdata[0]              = en_q;
      4'd1:    rdata[PrescWidth-1:0] = presc_q;
      4'd2:    rdata[Width-1:0]      = period_sh_q;
      4'd3:    rdata[Channels-1:0]   = pol_q;
      default: begin
        for (int n = 0; n < Channels; n++) begin
          if (wb_adr_i == 4'(n + 4)) rdata[Width-1:0] = duty_sh_q[n];
        end
      end
    endcase
  end

  // The >= compare lets a lowered PRESC take effect without the prescaler running away.
  assign tick   = en_q & (pcnt_q >= presc_q);
  assign at_top = (cnt_q == period_act_q);

  always_comb begin
    pcnt_d       = pcnt_q;
    cnt_d        = cnt_q;
    reload       = 1'b0;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (!en_q) begin
      pcnt_d = '0;
      cnt_d  = '0;
      reload = 1'b1;
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + PrescWidth'(1);
      if (tick) begin
        if (at_top) begin
          cnt_d  = '0;
          reload = 1'b1;
        end else begin
          cnt_d = cnt_q + Width'(1);
        end
      end
    end
    if (reload) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end
    for (int n = 0; n < Channels; n++) begin
      raw[n] = (cnt_q < duty_act_q[n]);
    end
    pwm_d  = en_q ? (raw ^ pol_q) : pol_q;
    wrap_d = tick & at_top;
    ack_d  = wb_stb_i & ~ack_q;
    dat_d  = rd ? rdata : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q         <= 1'b0;
      presc_q      <= '0;
      pcnt_q       <= '0;
      period_sh_q  <= '1;
      period_act_q <= '1;
      cnt_q        <= '0;
      pol_q        <= '0;
      duty_sh_q    <= '{default: '0};
      duty_act_q   <= '{default: '0};
      pwm_q        <= '0;
      wrap_q       <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      en_q         <= en_d;
      presc_q      <= presc_d;
      pcnt_q       <= pcnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      pol_q        <= pol_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
      wrap_q       <= wrap_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign wrap_o   = wrap_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule
